// File: rtl/connected.sv
// Inverse-factorial engine: finds n such that n! equals the loaded operand.
// Two accumulators: a holds n!, b builds the next product by repeated addition.
module connected (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ACCInput,
  output logic [4:0]  State,
  output logic [15:0] ACC
);

  typedef enum logic [4:0] {
    IDLE     = 5'd0,
    LOAD     = 5'd1,
    CMP      = 5'd2,
    INC      = 5'd3,
    MUL_INIT = 5'd4,
    MUL_ADD  = 5'd5,
    MUL_DONE = 5'd6,
    FOUND    = 5'd7,
    NOTFOUND = 5'd8
  } state_t;

  state_t      st;
  logic [15:0] x;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] n;
  logic [15:0] k;
  logic [16:0] sum;

  assign State = st;
  assign sum   = {1'b0, b} + {1'b0, a};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      st  <= IDLE;
      ACC <= 16'd0;
      x   <= 16'd0;
      a   <= 16'd0;
      b   <= 16'd0;
      n   <= 16'd0;
      k   <= 16'd0;
    end else begin
      case (st)
        IDLE: begin
          st <= LOAD;
        end
        LOAD: begin
          x   <= ACCInput;
          a   <= 16'd1;
          n   <= 16'd1;
          ACC <= 16'd1;
          st  <= CMP;
        end
        CMP: begin
          if (a == x) begin
            ACC <= n;
            st  <= FOUND;
          end else if (a > x) begin
            ACC <= 16'hFFFF;
            st  <= NOTFOUND;
          end else begin
            ACC <= n;
            st  <= INC;
          end
        end
        INC: begin
          n   <= n + 16'd1;
          ACC <= n + 16'd1;
          st  <= MUL_INIT;
        end
        MUL_INIT: begin
          b   <= 16'd0;
          k   <= n;
          ACC <= n;
          st  <= MUL_ADD;
        end
        MUL_ADD: begin
          b <= sum[15:0];
          k <= k - 16'd1;
          // carry out means n! no longer fits, so no larger n can match
          if (sum[16]) begin
            ACC <= 16'hFFFF;
            st  <= NOTFOUND;
          end else if (k == 16'd1) begin
            ACC <= n;
            st  <= MUL_DONE;
          end else begin
            ACC <= n;
          end
        end
        MUL_DONE: begin
          a   <= b;
          ACC <= n;
          st  <= CMP;
        end
        FOUND: begin
          ACC <= n;
        end
        NOTFOUND: begin
          ACC <= 16'hFFFF;
        end
        default: begin
          st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connected.sv
// Bench for connected: vector table, hand sequences and a
// randomized run against an arithmetic inverse-factorial model.
module tb_connected;

  logic        CLK;
  logic        RST;
  logic [15:0] ACCInput;
  logic [4:0]  State;
  logic [15:0] ACC;

  int checks = 0;
  int errors = 0;

  connected dut (
    .CLK      (CLK),
    .RST      (RST),
    .ACCInput (ACCInput),
    .State    (State),
    .ACC      (ACC)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] x;
    logic [4:0]  st;
    logic [15:0] acc;
  } vec_t;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Model: smallest i with i! >= x, plus clock count to a terminal state.
  task automatic model(input int xv, output int st, output int acc,
                       output int lat);
    int f;
    int i;
    f   = 1;
    i   = 1;
    lat = 3;
    while (f < xv) begin
      i++;
      f = f * i;
      if (f > 65535) lat += 4;
      else           lat += i + 4;
    end
    if (f == xv) begin
      st  = 7;
      acc = i;
    end else begin
      st  = 8;
      acc = 16'hFFFF;
    end
  endtask

  task automatic start(input logic [15:0] xv);
    RST      = 1'b0;
    ACCInput = xv;
    repeat (4) @(posedge CLK);
    #1;
    check("reset_state", State, 0);
    check("reset_acc", ACC, 0);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic wait_done(output int cyc, output bit ok);
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      cyc++;
      if (State == 5'd7 || State == 5'd8) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_muladd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK);
      #1;
      if (State == 5'd5) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  vec_t vecs[10];

  initial begin
    int cyc;
    bit ok;
    int est;
    int eacc;
    int elat;
    int bad;
    logic [15:0] rx;

    RST      = 1'b0;
    ACCInput = 16'd0;

    vecs[0] = '{16'd5040,  5'd7, 16'd7};
    vecs[1] = '{16'd1,     5'd7, 16'd1};
    vecs[2] = '{16'd40320, 5'd7, 16'd8};
    vecs[3] = '{16'd2,     5'd7, 16'd2};
    vecs[4] = '{16'd5041,  5'd8, 16'hFFFF};
    vecs[5] = '{16'd0,     5'd8, 16'hFFFF};
    vecs[6] = '{16'd65535, 5'd8, 16'hFFFF};
    vecs[7] = '{16'd720,   5'd7, 16'd6};
    vecs[8] = '{16'd3,     5'd8, 16'hFFFF};
    vecs[9] = '{16'd40319, 5'd8, 16'hFFFF};

    for (int v = 0; v < 10; v++) begin
      start(vecs[v].x);
      wait_done(cyc, ok);
      check($sformatf("done_%0d", vecs[v].x), ok, 1);
      check($sformatf("state_%0d", vecs[v].x), State, vecs[v].st);
      check($sformatf("acc_%0d", vecs[v].x), ACC, vecs[v].acc);
    end

    // exact latency for 5040 plus long-term hold of the result
    start(16'd5040);
    wait_done(cyc, ok);
    check("lat_5040", cyc, 54);
    check("state_5040_l", State, 7);
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(posedge CLK);
      #1;
      if (State != 5'd7 || ACC != 16'd7) bad++;
    end
    check("hold_5040", bad, 0);

    // first steps: IDLE -> LOAD -> CMP with ACC mirroring N=1
    start(16'd100);
    @(posedge CLK);
    #1;
    check("step1_state", State, 1);
    check("step1_acc", ACC, 0);
    @(posedge CLK);
    #1;
    check("step2_state", State, 2);
    check("step2_acc", ACC, 1);

    // asynchronous abort in MUL_ADD, then restart with a new operand
    start(16'd5040);
    wait_muladd(ok);
    check("reach_muladd", ok, 1);
    @(negedge CLK);
    RST = 1'b0;
    #1;
    check("abort_state", State, 0);
    check("abort_acc", ACC, 0);
    ACCInput = 16'd720;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    wait_done(cyc, ok);
    check("restart_state", State, 7);
    check("restart_acc", ACC, 6);

    // operand changes after LOAD are ignored
    start(16'd5040);
    wait_muladd(ok);
    check("reach_muladd2", ok, 1);
    ACCInput = 16'd24;
    wait_done(cyc, ok);
    check("late_in_state", State, 7);
    check("late_in_acc", ACC, 7);

    // randomized operands against the arithmetic model
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 2))
        0: rx = 16'($urandom_range(0, 65535));
        1: rx = 16'($urandom_range(0, 130));
        default: begin
          int f;
          f = 1;
          for (int j = 2; j <= int'($urandom_range(1, 8)); j++) f *= j;
          rx = 16'(f + int'($urandom_range(0, 2)) - 1);
        end
      endcase
      model(int'(rx), est, eacc, elat);
      start(rx);
      wait_done(cyc, ok);
      check($sformatf("rnd_state_%0d", rx), State, est);
      check($sformatf("rnd_acc_%0d", rx), ACC, eacc);
      check($sformatf("rnd_lat_%0d", rx), cyc, elat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/connected.md
CONNECTED -- requirements
Module: connected

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 RST  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 ACCInput  input  16  unsigned operand X, sampled once, in LOAD only.
REQ-005 State  output  5  current control-FSM state code (registered).
REQ-006 ACC  output  16  result accumulator (registered).

Function
REQ-007 The block SHALL be a two-accumulator multicycle processor computing the inverse factorial: find n with n! == X.
REQ-008 Internal registers SHALL be X(16), A (product accumulator, 16), B (second accumulator, 16), N(16), K(16).
REQ-009 State codes SHALL be: IDLE=0, LOAD=1, CMP=2, INC=3, MUL_INIT=4, MUL_ADD=5, MUL_DONE=6, FOUND=7, NOTFOUND=8.
REQ-010 IDLE SHALL go unconditionally to LOAD on the next clock.
REQ-011 LOAD SHALL set X<=ACCInput, A<=1, N<=1, then go to CMP.
REQ-012 CMP SHALL test in priority order: A==X -> FOUND; A>X (unsigned) -> NOTFOUND; otherwise -> INC.
REQ-013 INC SHALL set N<=N+1, then go to MUL_INIT.
REQ-014 MUL_INIT SHALL set B<=0 and K<=N, then go to MUL_ADD.
REQ-015 MUL_ADD SHALL perform one add per cycle: {carry,B}<=B+A and K<=K-1.
  - carry=1 -> NOTFOUND (overflow).
  - else K==1 before decrement -> MUL_DONE.
  - else stay in MUL_ADD.
REQ-016 MUL_DONE SHALL set A<=B (so A = N!), then go to CMP.
REQ-017 FOUND SHALL hold ACC=N and remain in FOUND until reset.
REQ-018 NOTFOUND SHALL hold ACC=16'hFFFF and remain in NOTFOUND until reset.
REQ-019 In LOAD through MUL_DONE, ACC SHALL mirror the value N will hold after the current edge.
REQ-020 Unused state codes 9..31 SHALL go to IDLE on the next clock.
REQ-021 Boundary values:
  - X=0 -> NOTFOUND (A=1>0).
  - X=1 -> FOUND, ACC=1.
  - Largest representable result is 8 (8!=40320).
  - Any X that is not a factorial in 1..40320 ends in NOTFOUND, via CMP (A>X) or MUL_ADD carry.
REQ-022 ACCInput changes after LOAD SHALL have no effect until the next reset.
REQ-023 Latency: X=5040 SHALL reach FOUND 53 clocks after the first rising edge with RST high.
  - Per iteration n: INC + MUL_INIT + n adds + MUL_DONE + CMP = n+4 clocks.
  - Plus LOAD and the first CMP.

Reset
REQ-024 While RST=0, asynchronously: State=0 (IDLE), ACC=0, X=A=B=N=K=0.
REQ-025 Reset asserted mid-operation SHALL abort immediately; after release the block restarts at IDLE and resamples ACCInput in LOAD.

Verification
REQ-026 RST=0 for 4 clocks, ACCInput=5040, release -> State=7 and ACC=7 within 64 clocks; both stable for 10000 further clocks.
REQ-027 ACCInput=1 -> State=7, ACC=1. ACCInput=40320 -> State=7, ACC=8. ACCInput=2 -> ACC=2.
REQ-028 ACCInput=5041 -> State=8, ACC=16'hFFFF. ACCInput=0 -> State=8, ACC=16'hFFFF.
REQ-029 ACCInput=65535 -> overflow path (carry during N=9 multiply) -> State=8, ACC=16'hFFFF.
REQ-030 Assert RST=0 while State=5 -> State=0 and ACC=0 before the next clock edge; change ACCInput to 720, release -> State=7, ACC=6.
REQ-031 Change ACCInput from 5040 to 24 while in MUL_ADD -> final ACC still 7.
